// File: rtl/ltc2600_frame_receiver.sv
// LTC2600 serial-port receiver: decodes csb/sck/sdi frames into per-channel
// input, DAC and power-down registers the way the DAC itself does.
// It only observes the bus and never drives it.
module ltc2600_frame_receiver #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned N_CH        = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_sck,
    input  logic                       i_sdi,
    input  logic                       i_csb,
    input  logic                       i_clrb,
    output logic                       o_frame_valid,
    output logic [3:0]                 o_frame_cmd,
    output logic [3:0]                 o_frame_addr,
    output logic [DATA_WIDTH-1:0]      o_frame_data,
    output logic                       o_frame_error,
    output logic                       o_clear_pulse,
    output logic [N_CH*DATA_WIDTH-1:0] o_dac_value,
    output logic [N_CH-1:0]            o_pwr_down
);

    localparam int unsigned ShortLen = DATA_WIDTH + 8;
    localparam int unsigned LongLen  = DATA_WIDTH + 16;
    localparam logic [5:0]  CntMax   = 6'd63;
    // Reset values of the {sck, sdi, csb, clrb} synchronizers: bus idle.
    localparam logic [3:0]  SyncRst  = 4'b0011;

    typedef enum logic {StIdle, StShift} state_e;

    logic [SYNC_STAGES-1:0][3:0]      r_sync;
    logic                             r_sck_d, r_csb_d, r_clrb_d;
    logic [3:0]                       w_sync;
    logic                             w_sck_s, w_sdi_s, w_csb_s, w_clrb_s;
    logic                             w_sck_rise, w_csb_fall, w_csb_rise, w_clrb_fall;
    state_e                           r_state, w_state_next;
    logic                             w_start, w_shift, w_end;
    // Only the last ShortLen bits matter; the leading byte of a long frame
    // simply falls off the top of the shift register.
    logic [ShortLen-1:0]              r_shreg;
    logic [5:0]                       r_bit_cnt;
    logic                             r_eval;
    logic                             w_len_ok;
    logic [3:0]                       w_cmd, w_addr;
    logic [DATA_WIDTH-1:0]            w_data;
    logic [N_CH-1:0]                  w_sel;
    logic [N_CH-1:0][DATA_WIDTH-1:0]  r_input, r_dac, w_input_d, w_dac_d;
    logic [N_CH-1:0]                  r_pwr, w_pwr_d;
    logic                             r_frame_valid, r_frame_error, r_clear_pulse;
    logic [3:0]                       r_frame_cmd, r_frame_addr;
    logic [DATA_WIDTH-1:0]            r_frame_data;

    // Synchronize the four serial inputs, plus one edge-detect flop each.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= {SYNC_STAGES{SyncRst}};
            r_sck_d  <= SyncRst[3];
            r_csb_d  <= SyncRst[1];
            r_clrb_d <= SyncRst[0];
        end else begin
            r_sync[0] <= {i_sck, i_sdi, i_csb, i_clrb};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_sck_d  <= w_sck_s;
            r_csb_d  <= w_csb_s;
            r_clrb_d <= w_clrb_s;
        end
    end

    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_sck_s     = w_sync[3];
    assign w_sdi_s     = w_sync[2];
    assign w_csb_s     = w_sync[1];
    assign w_clrb_s    = w_sync[0];
    assign w_sck_rise  = w_sck_s & ~r_sck_d;
    assign w_csb_fall  = ~w_csb_s & r_csb_d;
    assign w_csb_rise  = w_csb_s & ~r_csb_d;
    assign w_clrb_fall = ~w_clrb_s & r_clrb_d;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // FSM next state: a frame spans csb_s falling to csb_s rising.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_csb_fall) w_state_next = StShift;
            StShift: if (w_csb_rise) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs: the last sck edge coinciding with csb rising still shifts.
    always_comb begin
        w_start = (r_state == StIdle) && w_csb_fall;
        w_shift = (r_state == StShift) && w_sck_rise;
        w_end   = (r_state == StShift) && w_csb_rise;
    end

    // Shift register, saturating bit counter and end-of-frame strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_eval    <= 1'b0;
        end else begin
            r_eval <= w_end;
            if (w_start) begin
                r_shreg   <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_shreg   <= {r_shreg[ShortLen-2:0], w_sdi_s};
                r_bit_cnt <= (r_bit_cnt == CntMax) ? r_bit_cnt : r_bit_cnt + 6'd1;
            end
        end
    end

    assign w_len_ok = r_eval &&
                      ((r_bit_cnt == 6'(ShortLen)) || (r_bit_cnt == 6'(LongLen)));
    assign w_cmd    = r_shreg[DATA_WIDTH+7 -: 4];
    assign w_addr   = r_shreg[DATA_WIDTH+3 -: 4];
    assign w_data   = r_shreg[DATA_WIDTH-1:0];

    // Command decode into next register values; an active clear wins.
    always_comb begin
        w_input_d = r_input;
        w_dac_d   = r_dac;
        w_pwr_d   = r_pwr;
        w_sel     = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sel[i] = (w_addr == 4'hF) || (w_addr == 4'(i));
        end
        if (w_len_ok) begin
            case (w_cmd)
                4'h0: for (int i = 0; i < N_CH; i++) begin
                    if (w_sel[i]) w_input_d[i] = w_data;
                end
                4'h1: for (int i = 0; i < N_CH; i++) begin
                    if (w_sel[i]) begin
                        w_dac_d[i] = r_input[i];
                        w_pwr_d[i] = 1'b0;
                    end
                end
                4'h2: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (w_sel[i]) w_input_d[i] = w_data;
                        w_dac_d[i] = w_input_d[i];
                    end
                    w_pwr_d = '0;
                end
                4'h3: for (int i = 0; i < N_CH; i++) begin
                    if (w_sel[i]) begin
                        w_input_d[i] = w_data;
                        w_dac_d[i]   = w_data;
                        w_pwr_d[i]   = 1'b0;
                    end
                end
                4'h4: for (int i = 0; i < N_CH; i++) begin
                    if (w_sel[i]) w_pwr_d[i] = 1'b1;
                end
                default: ;
            endcase
        end
        if (!w_clrb_s) begin
            w_input_d = '0;
            w_dac_d   = '0;
        end
    end

    // Register file and reported frame fields/pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_input       <= '0;
            r_dac         <= '0;
            r_pwr         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            r_clear_pulse <= 1'b0;
            r_frame_cmd   <= '0;
            r_frame_addr  <= '0;
            r_frame_data  <= '0;
        end else begin
            r_input       <= w_input_d;
            r_dac         <= w_dac_d;
            r_pwr         <= w_pwr_d;
            r_frame_valid <= w_len_ok;
            r_frame_error <= r_eval && !w_len_ok;
            r_clear_pulse <= w_clrb_fall;
            if (w_len_ok) begin
                r_frame_cmd  <= w_cmd;
                r_frame_addr <= w_addr;
                r_frame_data <= w_data;
            end
        end
    end

    assign o_frame_valid = r_frame_valid;
    assign o_frame_error = r_frame_error;
    assign o_clear_pulse = r_clear_pulse;
    assign o_frame_cmd   = r_frame_cmd;
    assign o_frame_addr  = r_frame_addr;
    assign o_frame_data  = r_frame_data;
    assign o_dac_value   = r_dac;
    assign o_pwr_down    = r_pwr;

endmodule
